sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 21, SRAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 16, data width (signed num format, passed through untouched).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, WAIT-state limit (used only with SRAM_ARB_TIMEOUT_EN).
REQ-004 SHALL have port clk  in  1  single clock, rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports a_req, b_req  in  1 each  requester access request (level).
REQ-007 SHALL have ports a_we, b_we  in  1 each  1 = write, 0 = read.
REQ-008 SHALL have ports a_addr, b_addr  in  ADDR_W each  requester address.
REQ-009 SHALL have ports a_wdata, b_wdata  in  DATA_W each  requester write data.
REQ-010 SHALL have ports a_ack, b_ack  out  1 each  one-cycle completion pulse.
REQ-011 SHALL have ports a_rdata, b_rdata  out  DATA_W each  read result, valid with ack.
REQ-012 SHALL have ports mem_addr  out  ADDR_W, mem_wdata  out  DATA_W, and mem_rd, mem_wr  out  1  toward the SRAM access module.
REQ-013 SHALL have ports mem_rdata  in  DATA_W and mem_ready  in  1  from the SRAM access module.
REQ-014 SHALL have ports busy  out  1 (state != IDLE), grant  out  1 (0 = A, 1 = B), and timeout_err  out  1.

Function
REQ-015 SHALL implement states IDLE, ISSUE, WAIT, DONE; all outputs registered.
- IDLE: if any req is high, latch the winner's addr/we/wdata, set grant, then go to ISSUE.
- ISSUE: mem_rd or mem_wr high for exactly this cycle; go to DONE if mem_ready, else WAIT.
- WAIT: mem_rd = mem_wr = 0; go to DONE on mem_ready.
- DONE: winner's ack high for one cycle; then go to IDLE.
REQ-016 SHALL arbitrate round-robin; a lone requester wins regardless of the priority pointer; on simultaneous requests the pointer-selected requester wins.
REQ-017 SHALL point priority at the non-winner after every DONE cycle.
REQ-018 SHALL capture mem_rdata into the winner's rdata on the cycle mem_ready is sampled.
- On writes, rdata is left unchanged.
- The loser's rdata and ack are never disturbed.
REQ-019 SHALL hold mem_addr and mem_wdata stable from ISSUE through DONE.
REQ-020 SHALL give, for an uncontended request rising before edge N, mem strobe during cycle N+1 and ack at earliest cycle N+2 (mem_ready during ISSUE).
REQ-021 Requesters SHALL hold req/we/addr/wdata stable until ack and deassert req on the edge that samples ack; the arbiter need not tolerate violations.
REQ-022 SHALL ignore mem_ready in IDLE and DONE.

Reset
REQ-023 SHALL, while reset is low, force state IDLE, priority pointer to A, and all outputs to 0 (acks, strobes, rdata, mem_addr, mem_wdata, grant, busy, timeout_err).
REQ-024 SHALL abandon any in-flight access on reset assertion, with no ack issued for it after reset release.

Configuration
REQ-025 SHALL, when SRAM_ARB_TIMEOUT_EN is defined, behave as follows:
- Count WAIT cycles, saturating.
- After TIMEOUT_CYCLES cycles without mem_ready, go to DONE, ack the winner with rdata = 0, and set timeout_err sticky until reset.
REQ-026 SHALL, when SRAM_ARB_TIMEOUT_EN is undefined, wait indefinitely in WAIT, tie timeout_err to 0, and include no counter logic.

Verification
REQ-027 Single read: a_req, a_we=0, a_addr=0x00010, model returns 0x8008 with mem_ready 3 cycles after mem_rd -> one mem_rd pulse at addr 0x00010, a_ack one cycle, a_rdata=0x8008, b_ack stays 0.
REQ-028 Contention: a_req and b_req rise on the same edge after reset -> A served first, then B, grant 0 then 1, exactly two strobes, no overlap.
REQ-029 Fairness: A and B both held requesting for 6 accesses -> grants alternate A,B,A,B,A,B.
REQ-030 Write path: b_we=1, b_addr=0x1FFFFF, b_wdata=0xFFFF -> mem_wr one cycle with those values, b_ack, b_rdata unchanged.
REQ-031 Reset mid-access: reset low during WAIT for A -> all outputs 0 immediately; after release, a_ack never pulses for the abandoned access; a new B request is served normally.
REQ-032 Timeout (SRAM_ARB_TIMEOUT_EN defined): mem_ready never asserted -> a_ack 255 cycles after entering WAIT, a_rdata=0, timeout_err=1 and held.

Source files
------------

// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
//   Two-requester round-robin arbiter in front of a single-port SRAM access
//   module. Each access runs IDLE -> ISSUE -> (WAIT) -> DONE, with every
//   output driven straight from a flop.
//
//   Optional feature macro: SRAM_ARB_TIMEOUT_EN
//     defined   : WAIT gives up after TIMEOUT_CYCLES cycles without
//                 mem_ready, acks the winner with rdata = 0 and sets a
//                 sticky timeout_err.
//     undefined : WAIT waits forever; timeout_err is tied low and no
//                 counter is built.
//
// Ports
//   clk, reset             clock (rising edge), async active-low reset
//   a_* / b_*              requester A / B: req, we, addr, wdata in;
//                          ack (1-cycle pulse), rdata (valid with ack) out
//   mem_addr, mem_wdata    address / write data toward the SRAM, held
//                          stable from ISSUE through DONE
//   mem_rd, mem_wr         one-cycle strobes, high only in ISSUE
//   mem_rdata, mem_ready   read data / completion from the SRAM
//   busy                   state != IDLE
//   grant                  current/last winner (0 = A, 1 = B)
//   timeout_err            sticky WAIT timeout flag
// ---------------------------------------------------------------------------
module sram_arbiter #(
    parameter int ADDR_W         = 21,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,

    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,

    output logic              busy,
    output logic              grant,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    logic   prio;     // 0: A wins a tie, 1: B wins a tie
    logic   we_q;     // direction of the access in flight
    logic   win_b;    // IDLE-time winner select

    // A lone requester always wins; the pointer only breaks ties.
    always_comb win_b = b_req & (~a_req | prio);

`ifdef SRAM_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             wait_expired;

    // wait_cnt holds the number of WAIT cycles already completed, so the
    // edge ending the TIMEOUT_CYCLES-th WAIT cycle sees TIMEOUT_CYCLES-1.
    always_comb wait_expired = (wait_cnt >= CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            prio        <= 1'b0;
            we_q        <= 1'b0;
            grant       <= 1'b0;
            busy        <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            a_ack       <= 1'b0;
            b_ack       <= 1'b0;
            a_rdata     <= '0;
            b_rdata     <= '0;
`ifdef SRAM_ARB_TIMEOUT_EN
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (a_req | b_req) begin
                        grant     <= win_b;
                        we_q      <= win_b ? b_we : a_we;
                        mem_addr  <= win_b ? b_addr : a_addr;
                        mem_wdata <= win_b ? b_wdata : a_wdata;
                        mem_rd    <= ~(win_b ? b_we : a_we);
                        mem_wr    <=  (win_b ? b_we : a_we);
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end

                // ISSUE and WAIT share completion handling; only the
                // strobe cycle and the timeout differ between them.
                ISSUE, WAIT: begin
                    mem_rd <= 1'b0;
                    mem_wr <= 1'b0;
                    if (mem_ready) begin
                        state <= DONE;
                        if (grant) b_ack <= 1'b1;
                        else       a_ack <= 1'b1;
                        if (!we_q) begin
                            if (grant) b_rdata <= mem_rdata;
                            else       a_rdata <= mem_rdata;
                        end
                    end
`ifdef SRAM_ARB_TIMEOUT_EN
                    else if (state == WAIT && wait_expired) begin
                        state       <= DONE;
                        timeout_err <= 1'b1;
                        if (grant) begin
                            b_ack   <= 1'b1;
                            b_rdata <= '0;
                        end else begin
                            a_ack   <= 1'b1;
                            a_rdata <= '0;
                        end
                    end
`endif
                    else begin
                        state <= WAIT;
`ifdef SRAM_ARB_TIMEOUT_EN
                        if (state == ISSUE)
                            wait_cnt <= '0;
                        else if (wait_cnt != '1)
                            wait_cnt <= wait_cnt + CNT_W'(1);
`endif
                    end
                end

                DONE: begin
                    a_ack <= 1'b0;
                    b_ack <= 1'b0;
                    busy  <= 1'b0;
                    prio  <= ~grant;   // the non-winner gets the next tie
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_arbiter
//   Directed bench for sram_arbiter. A small SRAM model answers strobes
//   after a programmable latency (or never), logs each strobe, and counts
//   acks; each test task drives requesters and compares inline.
// ---------------------------------------------------------------------------
module tb_sram_arbiter;

    localparam int AW = 21;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_ack, b_ack;
    logic [DW-1:0] a_rdata, b_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rd, mem_wr;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          busy, grant, timeout_err;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(255)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .busy(busy), .grant(grant), .timeout_err(timeout_err)
    );

    // ---------------- SRAM model / monitor ----------------
    int            lat = 0;
    bit            hang = 0;
    bit            fix_en = 0;
    logic [DW-1:0] fix_val = '0;
    int            strobes = 0, overlap_err = 0, stab_err = 0;
    int            a_acks = 0, b_acks = 0;
    logic [AW-1:0] log_addr = '0;
    logic [DW-1:0] log_wd = '0;
    logic          log_we = 1'b0;
    logic          grant_log [0:31];

    function automatic logic [DW-1:0] exp_rdata(input logic [AW-1:0] a);
        return DW'(a) ^ 16'hA5A5;
    endfunction

    initial begin
        int  cnt;
        bit  pend;
        cnt = 0; pend = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (a_ack) a_acks++;
            if (b_ack) b_acks++;
            if (!reset) begin
                pend = 0;
            end else begin
                if (mem_rd & mem_wr) overlap_err++;
                if (mem_rd | mem_wr) begin
                    if (strobes < 32) grant_log[strobes] = grant;
                    strobes++;
                    log_addr  = mem_addr;
                    log_wd    = mem_wdata;
                    log_we    = mem_wr;
                    mem_rdata = fix_en ? fix_val : exp_rdata(mem_addr);
                    if (!hang) begin
                        if (lat == 0) mem_ready = 1'b1;
                        else begin pend = 1; cnt = lat; end
                    end
                end else if (pend) begin
                    cnt--;
                    if (cnt == 0) begin mem_ready = 1'b1; pend = 0; end
                end
                if (busy && (mem_addr !== log_addr || mem_wdata !== log_wd)) stab_err++;
            end
        end
    end

    // ---------------- requester helpers ----------------
    task automatic access(input bit side, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, input int budget, output bit ok);
        ok = 0;
        if (!side) begin a_req = 1; a_we = we; a_addr = addr; a_wdata = wd; end
        else       begin b_req = 1; b_we = we; b_addr = addr; b_wdata = wd; end
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((!side && a_ack) || (side && b_ack)) begin ok = 1; break; end
        end
        if (!side) a_req = 0; else b_req = 0;
    endtask

    task automatic do_reset();
        reset = 0;
        a_req = 0; b_req = 0; a_we = 0; b_we = 0;
        a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
        hang = 0; fix_en = 0; lat = 0;
        repeat (3) @(negedge clk);
        reset = 1;
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        reset = 0;
        #1;
        vecs++;
        if ({a_ack, b_ack, mem_rd, mem_wr, busy, grant, timeout_err} !== 7'b0) begin
            errs++; $display("FAIL reset_ctrl: got %b want 0", {a_ack, b_ack, mem_rd, mem_wr, busy, grant, timeout_err});
        end
        vecs++;
        if ({a_rdata, b_rdata, mem_addr, mem_wdata} !== '0) begin
            errs++; $display("FAIL reset_data: got %h want 0", {a_rdata, b_rdata, mem_addr, mem_wdata});
        end
        @(negedge clk);
        reset = 1;
        @(negedge clk);
    endtask

    task automatic test_latency();
        do_reset();
        a_req = 1; a_we = 0; a_addr = 21'h00123;
        @(negedge clk);
        vecs++;
        if ({mem_rd, mem_wr, busy} !== 3'b101) begin
            errs++; $display("FAIL lat_strobe: rd/wr/busy got %b want 101", {mem_rd, mem_wr, busy});
        end
        vecs++;
        if (mem_addr !== 21'h00123) begin
            errs++; $display("FAIL lat_addr: got %h want 00123", mem_addr);
        end
        @(negedge clk);
        vecs++;
        if ({a_ack, b_ack, mem_rd} !== 3'b100) begin
            errs++; $display("FAIL lat_ack: a_ack/b_ack/rd got %b want 100", {a_ack, b_ack, mem_rd});
        end
        vecs++;
        if (a_rdata !== exp_rdata(21'h00123)) begin
            errs++; $display("FAIL lat_rdata: got %h want %h", a_rdata, exp_rdata(21'h00123));
        end
        a_req = 0;
        @(negedge clk);
        vecs++;
        if ({a_ack, busy} !== 2'b00) begin
            errs++; $display("FAIL lat_ack_width: ack/busy got %b want 00", {a_ack, busy});
        end
    endtask

    task automatic test_single_read();
        int s0, a0, b0;
        bit ok;
        do_reset();
        lat = 3; fix_en = 1; fix_val = 16'h8008;
        s0 = strobes; a0 = a_acks; b0 = b_acks;
        access(0, 0, 21'h00010, '0, 50, ok);
        repeat (2) @(negedge clk);
        vecs++;
        if (!ok) begin errs++; $display("FAIL rd_ack_timeout: no a_ack within bound"); end
        vecs++;
        if (strobes - s0 != 1 || log_we !== 1'b0 || log_addr !== 21'h00010) begin
            errs++; $display("FAIL rd_strobe: n=%0d we=%b addr=%h want n=1 we=0 addr=00010",
                             strobes - s0, log_we, log_addr);
        end
        vecs++;
        if (a_acks - a0 != 1 || b_acks - b0 != 0) begin
            errs++; $display("FAIL rd_acks: a=%0d b=%0d want a=1 b=0", a_acks - a0, b_acks - b0);
        end
        vecs++;
        if (a_rdata !== 16'h8008) begin
            errs++; $display("FAIL rd_data: got %h want 8008", a_rdata);
        end
        fix_en = 0;
    endtask

    task automatic test_contention();
        int s0;
        bit oka, okb;
        do_reset();
        lat = 1;
        s0 = strobes;
        fork
            access(0, 0, 21'h00AAA, '0, 50, oka);
            access(1, 0, 21'h15555, '0, 50, okb);
        join
        repeat (2) @(negedge clk);
        vecs++;
        if (!oka || !okb) begin errs++; $display("FAIL cont_acks: okA=%b okB=%b want 1 1", oka, okb); end
        vecs++;
        if (strobes - s0 != 2 || grant_log[s0] !== 1'b0 || grant_log[s0+1] !== 1'b1) begin
            errs++; $display("FAIL cont_order: n=%0d g=%b%b want n=2 g=01",
                             strobes - s0, grant_log[s0], grant_log[s0+1]);
        end
        vecs++;
        if (overlap_err != 0 || stab_err != 0) begin
            errs++; $display("FAIL cont_bus: overlap=%0d unstable=%0d want 0 0", overlap_err, stab_err);
        end
        vecs++;
        if (a_rdata !== exp_rdata(21'h00AAA) || b_rdata !== exp_rdata(21'h15555)) begin
            errs++; $display("FAIL cont_rdata: a=%h b=%h want %h %h", a_rdata, b_rdata,
                             exp_rdata(21'h00AAA), exp_rdata(21'h15555));
        end
    endtask

    task automatic test_fairness();
        int s0;
        do_reset();
        s0 = strobes;
        fork
            begin
                bit ok;
                for (int i = 0; i < 3; i++) access(0, 0, AW'(21'h00100 + i), '0, 60, ok);
            end
            begin
                bit ok;
                for (int i = 0; i < 3; i++) access(1, 0, AW'(21'h00200 + i), '0, 60, ok);
            end
        join
        repeat (2) @(negedge clk);
        vecs++;
        if (strobes - s0 != 6) begin
            errs++; $display("FAIL fair_count: got %0d want 6", strobes - s0);
        end
        for (int i = 0; i < 6; i++) begin
            vecs++;
            if (grant_log[s0+i] !== 1'(i % 2)) begin
                errs++; $display("FAIL fair_grant%0d: got %b want %b", i, grant_log[s0+i], 1'(i % 2));
            end
        end
    endtask

    task automatic test_write();
        int s0, a0, b0;
        bit ok;
        access(1, 0, 21'h00042, '0, 50, ok);   // give b_rdata a known value
        @(negedge clk);
        s0 = strobes; a0 = a_acks; b0 = b_acks;
        access(1, 1, 21'h1FFFFF, 16'hFFFF, 50, ok);
        repeat (2) @(negedge clk);
        vecs++;
        if (!ok) begin errs++; $display("FAIL wr_ack_timeout: no b_ack within bound"); end
        vecs++;
        if (strobes - s0 != 1 || log_we !== 1'b1 || log_addr !== 21'h1FFFFF || log_wd !== 16'hFFFF) begin
            errs++; $display("FAIL wr_strobe: n=%0d we=%b addr=%h wd=%h want 1 1 1fffff ffff",
                             strobes - s0, log_we, log_addr, log_wd);
        end
        vecs++;
        if (b_rdata !== exp_rdata(21'h00042)) begin
            errs++; $display("FAIL wr_rdata_kept: got %h want %h", b_rdata, exp_rdata(21'h00042));
        end
        vecs++;
        if (b_acks - b0 != 1 || a_acks - a0 != 0) begin
            errs++; $display("FAIL wr_acks: b=%0d a=%0d want 1 0", b_acks - b0, a_acks - a0);
        end
    endtask

    task automatic test_reset_mid();
        int  a0;
        bit  ok;
        hang = 1;
        a_req = 1; a_we = 0; a_addr = 21'h00333; a_wdata = 16'h1234;
        for (int i = 0; i < 10 && !(busy && !mem_rd && state_is_wait()); i++) @(negedge clk);
        vecs++;
        if (!(busy && !mem_rd)) begin errs++; $display("FAIL rst_mid_wait: never reached WAIT"); end
        @(negedge clk);
        reset = 0;
        #1;
        vecs++;
        if ({a_ack, b_ack, mem_rd, mem_wr, busy, grant, timeout_err} !== 7'b0) begin
            errs++; $display("FAIL rst_mid_ctrl: got %b want 0", {a_ack, b_ack, mem_rd, mem_wr, busy, grant, timeout_err});
        end
        vecs++;
        if ({a_rdata, b_rdata, mem_addr, mem_wdata} !== '0) begin
            errs++; $display("FAIL rst_mid_data: got %h want 0", {a_rdata, b_rdata, mem_addr, mem_wdata});
        end
        a_req = 0; hang = 0;
        a0 = a_acks;
        repeat (2) @(negedge clk);
        reset = 1;
        repeat (10) @(negedge clk);
        vecs++;
        if (a_acks != a0) begin errs++; $display("FAIL rst_mid_noack: got %0d stray acks want 0", a_acks - a0); end
        access(1, 0, 21'h00777, '0, 50, ok);
        repeat (2) @(negedge clk);
        vecs++;
        if (!ok || b_rdata !== exp_rdata(21'h00777) || a_acks != a0) begin
            errs++; $display("FAIL rst_mid_b: ok=%b rdata=%h stray=%0d want 1 %h 0",
                             ok, b_rdata, a_acks - a0, exp_rdata(21'h00777));
        end
    endtask

    // WAIT is the only busy state with no strobe and no ack.
    function automatic bit state_is_wait();
        return busy && !mem_rd && !mem_wr && !a_ack && !b_ack;
    endfunction

`ifdef SRAM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        int n;
        do_reset();
        access(0, 0, 21'h00055, '0, 50, ok);     // a_rdata becomes nonzero
        @(negedge clk);
        hang = 1;
        a_req = 1; a_we = 0; a_addr = 21'h00056;
        for (int i = 0; i < 5 && !mem_rd; i++) @(negedge clk);
        n = 0;
        while (!a_ack && n < 400) begin @(negedge clk); n++; end
        vecs++;
        if (n != 256) begin errs++; $display("FAIL to_latency: ack %0d cycles after ISSUE want 256", n); end
        vecs++;
        if (a_rdata !== '0 || timeout_err !== 1'b1) begin
            errs++; $display("FAIL to_ack: rdata=%h err=%b want 0 1", a_rdata, timeout_err);
        end
        a_req = 0; hang = 0;
        repeat (5) @(negedge clk);
        vecs++;
        if (timeout_err !== 1'b1 || busy !== 1'b0) begin
            errs++; $display("FAIL to_sticky: err=%b busy=%b want 1 0", timeout_err, busy);
        end
    endtask
`endif

    initial begin
        reset = 0;
        a_req = 0; b_req = 0; a_we = 0; b_we = 0;
        a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
        test_reset();
        test_latency();
        test_single_read();
        test_contention();
        test_fairness();
        test_write();
        test_reset_mid();
`ifdef SRAM_ARB_TIMEOUT_EN
        test_timeout();
`else
        vecs++;
        if (timeout_err !== 1'b0) begin errs++; $display("FAIL no_timeout_err: got %b want 0", timeout_err); end
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
